// File: rtl/fp_cvt_pkg.sv
// ============================================================================
// Module  : fp_cvt_pkg
// Brief   : Shared types for the float/int conversion units.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package fp_cvt_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  typedef enum logic [2:0] {
    FC_ZERO = 3'd0,
    FC_SUB  = 3'd1,
    FC_NORM = 3'd2,
    FC_INF  = 3'd3,
    FC_NAN  = 3'd4
  } fclass_e;

  typedef struct packed {
    logic nv;
    logic nx;
  } cvt_flags_t;

  localparam int CVT_DEF_INT_W = 32;
  localparam logic [CVT_DEF_INT_W-1:0] CVT_SMAX = {1'b0, {(CVT_DEF_INT_W-1){1'b1}}};
  localparam logic [CVT_DEF_INT_W-1:0] CVT_SMIN = {1'b1, {(CVT_DEF_INT_W-1){1'b0}}};
  localparam logic [CVT_DEF_INT_W-1:0] CVT_UMAX = {CVT_DEF_INT_W{1'b1}};

  // Reserved encodings 5-7 fall back to round-to-nearest-even.
  function automatic rm_e decode_rm(input logic [2:0] raw);
    case (raw)
      3'd1:    return RM_RTZ;
      3'd2:    return RM_RDN;
      3'd3:    return RM_RUP;
      3'd4:    return RM_RMM;
      default: return RM_RNE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_to_int_pipe_if.sv
// ============================================================================
// Module  : fp_to_int_pipe_if
// Brief   : Operand and result channels of the float-to-int converter.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface fp_to_int_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int INT_W = 32,
  parameter int TAG_W = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [EXP_W+MAN_W:0]   in_f;
  logic                   in_unsigned;
  logic [2:0]             in_rm;
  logic [TAG_W-1:0]       in_tag;
  logic                   out_valid;
  logic                   out_ready;
  logic [INT_W-1:0]       out_int;
  logic                   out_nv;
  logic                   out_nx;
  logic [TAG_W-1:0]       out_tag;

  modport master (
    output in_valid, in_f, in_unsigned, in_rm, in_tag, out_ready,
    input  in_ready, out_valid, out_int, out_nv, out_nx, out_tag
  );

  modport slave (
    input  in_valid, in_f, in_unsigned, in_rm, in_tag, out_ready,
    output in_ready, out_valid, out_int, out_nv, out_nx, out_tag
  );
endinterface

`default_nettype wire

// File: rtl/fp_round_incr.sv
// ============================================================================
// Module  : fp_round_incr
// Brief   : Rounding-increment decision from rm, sign, lsb, guard and sticky.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module fp_round_incr
  import fp_cvt_pkg::*;
(
  input  rm_e  i_rm,
  input  logic i_sign,
  input  logic i_lsb,
  input  logic i_guard,
  input  logic i_sticky,
  output logic o_incr,
  output logic o_inexact
);

  logic w_inexact;

  assign w_inexact = i_guard | i_sticky;
  assign o_inexact = w_inexact;

  always_comb begin
    o_incr = 1'b0;
    case (i_rm)
      RM_RNE:  o_incr = i_guard & (i_sticky | i_lsb);
      RM_RTZ:  o_incr = 1'b0;
      RM_RDN:  o_incr = i_sign & w_inexact;
      RM_RUP:  o_incr = ~i_sign & w_inexact;
      RM_RMM:  o_incr = i_guard;
      default: o_incr = i_guard & (i_sticky | i_lsb);
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fp_to_int_pipe.sv
// ============================================================================
// Module  : fp_to_int_pipe
// Brief   : 3-stage IEEE-754 float to signed/unsigned integer converter.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module fp_to_int_pipe
  import fp_cvt_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int INT_W = 32,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fp_to_int_pipe_if.slave      bus
);

  localparam int c_FB = MAN_W + 2;
  localparam int c_XW = INT_W + MAN_W + 3;
  localparam logic signed [EXP_W:0] c_BIAS = {2'b00, {(EXP_W-1){1'b1}}};
  localparam logic [INT_W-1:0] c_SMAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] c_SMIN = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [INT_W-1:0] c_UMAX = {INT_W{1'b1}};
  localparam logic [INT_W+1:0] c_LIM_SPOS = {3'b000, {(INT_W-1){1'b1}}};
  localparam logic [INT_W+1:0] c_LIM_SNEG = {3'b001, {(INT_W-1){1'b0}}};
  localparam logic [INT_W+1:0] c_LIM_UPOS = {2'b00, {INT_W{1'b1}}};

  logic w_adv;
  assign w_adv       = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = w_adv;

  // ---------------- S1: unpack / classify ----------------
  logic [EXP_W-1:0]      w_exp;
  logic [EXP_W-1:0]      w_exp_eff;
  logic [MAN_W-1:0]      w_man;
  logic                  w_sign;
  logic signed [EXP_W:0] w_e_unb;
  fclass_e               w_class;

  assign w_exp     = bus.in_f[MAN_W +: EXP_W];
  assign w_man     = bus.in_f[MAN_W-1:0];
  assign w_sign    = bus.in_f[EXP_W+MAN_W];
  assign w_exp_eff = (w_exp == '0) ? {{(EXP_W-1){1'b0}}, 1'b1} : w_exp;
  assign w_e_unb   = $signed({1'b0, w_exp_eff}) - c_BIAS;

  always_comb begin
    w_class = FC_NORM;
    if (w_exp == '0)
      w_class = (w_man == '0) ? FC_ZERO : FC_SUB;
    else if (w_exp == '1)
      w_class = (w_man == '0) ? FC_INF : FC_NAN;
  end

  logic                  r_s1_valid;
  logic [TAG_W-1:0]      r_s1_tag;
  logic                  r_s1_uns;
  rm_e                   r_s1_rm;
  fclass_e               r_s1_class;
  logic                  r_s1_sign;
  logic signed [EXP_W:0] r_s1_exp;
  logic [MAN_W:0]        r_s1_sig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_tag   <= '0;
      r_s1_uns   <= 1'b0;
      r_s1_rm    <= RM_RNE;
      r_s1_class <= FC_ZERO;
      r_s1_sign  <= 1'b0;
      r_s1_exp   <= '0;
      r_s1_sig   <= '0;
    end else if (w_adv) begin
      r_s1_valid <= bus.in_valid;
      r_s1_tag   <= bus.in_tag;
      r_s1_uns   <= bus.in_unsigned;
      r_s1_rm    <= decode_rm(bus.in_rm);
      r_s1_class <= w_class;
      r_s1_sign  <= w_sign;
      r_s1_exp   <= w_e_unb;
      r_s1_sig   <= {(w_class == FC_NORM), w_man};
    end
  end

  // ---------------- S2: align ----------------
  // Fixed point with c_FB fraction bits: shifting by E+2 puts the binary point at c_FB.
  int               w_e_int;
  int               w_sh;
  logic             w_ovf;
  logic             w_tiny;
  logic [c_XW-1:0]  w_x;
  logic [INT_W:0]   w_mag;
  logic             w_guard;
  logic             w_rs;

  assign w_e_int = int'(r_s1_exp);
  assign w_ovf   = (w_e_int >= INT_W + 1);
  assign w_tiny  = (w_e_int < -1);
  assign w_sh    = (w_ovf || w_tiny) ? 0 : w_e_int + 2;
  assign w_x     = {{(INT_W+2){1'b0}}, r_s1_sig} << w_sh;
  assign w_mag   = w_tiny ? '0 : w_x[c_XW-1:c_FB];
  assign w_guard = w_tiny ? 1'b0 : w_x[c_FB-1];
  assign w_rs    = w_tiny ? (|r_s1_sig) : (w_x[c_FB-2] | (|w_x[c_FB-3:0]));

  logic             r_s2_valid;
  logic [TAG_W-1:0] r_s2_tag;
  logic             r_s2_uns;
  rm_e              r_s2_rm;
  fclass_e          r_s2_class;
  logic             r_s2_sign;
  logic             r_s2_ovf;
  logic [INT_W:0]   r_s2_mag;
  logic             r_s2_guard;
  logic             r_s2_rs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_tag   <= '0;
      r_s2_uns   <= 1'b0;
      r_s2_rm    <= RM_RNE;
      r_s2_class <= FC_ZERO;
      r_s2_sign  <= 1'b0;
      r_s2_ovf   <= 1'b0;
      r_s2_mag   <= '0;
      r_s2_guard <= 1'b0;
      r_s2_rs    <= 1'b0;
    end else if (w_adv) begin
      r_s2_valid <= r_s1_valid;
      r_s2_tag   <= r_s1_tag;
      r_s2_uns   <= r_s1_uns;
      r_s2_rm    <= r_s1_rm;
      r_s2_class <= r_s1_class;
      r_s2_sign  <= r_s1_sign;
      r_s2_ovf   <= w_ovf;
      r_s2_mag   <= w_mag;
      r_s2_guard <= w_guard;
      r_s2_rs    <= w_rs;
    end
  end

  // ---------------- S3: round / saturate ----------------
  logic             w_incr;
  logic             w_inexact;
  logic [INT_W+1:0] w_mag_r;
  logic [INT_W-1:0] w_sat;
  logic [INT_W-1:0] w_int;
  cvt_flags_t       w_flags;

  fp_round_incr u_round (
    .i_rm      (r_s2_rm),
    .i_sign    (r_s2_sign),
    .i_lsb     (r_s2_mag[0]),
    .i_guard   (r_s2_guard),
    .i_sticky  (r_s2_rs),
    .o_incr    (w_incr),
    .o_inexact (w_inexact)
  );

  assign w_mag_r = {1'b0, r_s2_mag} + {{(INT_W+1){1'b0}}, w_incr};
  assign w_sat   = r_s2_sign ? (r_s2_uns ? '0 : c_SMIN) : (r_s2_uns ? c_UMAX : c_SMAX);

  always_comb begin
    w_int   = '0;
    w_flags = '0;
    case (r_s2_class)
      FC_ZERO: w_int = '0;
      FC_NAN: begin
        w_int      = r_s2_uns ? c_UMAX : c_SMAX;
        w_flags.nv = 1'b1;
      end
      FC_INF: begin
        w_int      = w_sat;
        w_flags.nv = 1'b1;
      end
      default: begin
        if (r_s2_ovf
            || (r_s2_uns  && !r_s2_sign && (w_mag_r > c_LIM_UPOS))
            || (r_s2_uns  &&  r_s2_sign && (w_mag_r != '0))
            || (!r_s2_uns && !r_s2_sign && (w_mag_r > c_LIM_SPOS))
            || (!r_s2_uns &&  r_s2_sign && (w_mag_r > c_LIM_SNEG))) begin
          w_int      = w_sat;
          w_flags.nv = 1'b1;
        end else begin
          w_int      = (r_s2_sign && !r_s2_uns) ? ('0 - w_mag_r[INT_W-1:0]) : w_mag_r[INT_W-1:0];
          w_flags.nx = w_inexact;
        end
      end
    endcase
  end

  logic             r_out_valid;
  logic [INT_W-1:0] r_out_int;
  cvt_flags_t       r_out_flags;
  logic [TAG_W-1:0] r_out_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_int   <= '0;
      r_out_flags <= '0;
      r_out_tag   <= '0;
    end else if (w_adv) begin
      r_out_valid <= r_s2_valid;
      r_out_int   <= w_int;
      r_out_flags <= w_flags;
      r_out_tag   <= r_s2_tag;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_int   = r_out_int;
  assign bus.out_nv    = r_out_flags.nv;
  assign bus.out_nx    = r_out_flags.nx;
  assign bus.out_tag   = r_out_tag;

endmodule

`default_nettype wire
